// File: rtl/ib_sar_trim_pkg.sv
// Shared state encoding and front-end drive constants for the bias-current SAR trim sequencer.
package ib_sar_trim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIODE,
        BLANK1,
        BIGDIODE,
        BLANK2,
        COMPARE,
        DECIDE,
        DONE
    } state_t;

    localparam logic [7:0] DIODE_SMALL = 8'h01;
    localparam logic [7:0] DIODE_BIG   = 8'hFF;
    localparam logic [1:0] C_CHARGE    = 2'd2;
    localparam logic [1:0] C_HOLD      = 2'd1;
    localparam logic [1:0] C_OFF       = 2'd0;
    localparam logic [7:0] IB_MID      = 8'h80;
    localparam int         CMP_CYCLES  = 3;

    function automatic logic [7:0] bit_mask(input logic [2:0] b);
        return 8'h01 << b;
    endfunction

endpackage

// File: rtl/ib_sar_trim_ctrl_cmp_vote.sv
// Comparator synchronizer plus ones counter; majority_o is valid once all votes of a bit are in.
module cmp_vote #(
    parameter int NVOTE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmp_async_i,
    input  logic       sample_i,
    input  logic       clear_i,
    output logic [3:0] ones_o,
    output logic       majority_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic [3:0] ones_q;
    logic [3:0] ones_d;

    always_comb begin
        ones_d = ones_q;
        if (clear_i) begin
            ones_d = 4'd0;
        end else if (sample_i && sync2_q) begin
            ones_d = ones_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            ones_q  <= 4'd0;
        end else begin
            sync1_q <= cmp_async_i;
            sync2_q <= sync1_q;
            ones_q  <= ones_d;
        end
    end

    assign ones_o     = ones_q;
    assign majority_o = (ones_q > 4'(NVOTE / 2));

endmodule

// File: rtl/ib_sar_trim_ctrl.sv
// SAR trim of the 8-bit bias code: per bit, NVOTE diode/blank/bigdiode/blank/compare cycles then a majority decision.
module ib_sar_trim_ctrl
    import ib_sar_trim_pkg::*;
#(
    parameter int T_PH  = 1,
    parameter int T_BL  = 1,
    parameter int NVOTE = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       cmp_o,
    output logic [7:0] ib,
    output logic       res_n,
    output logic [7:0] diode,
    output logic [1:0] c1,
    output logic [1:0] c2,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic [7:0] code_o
);

    localparam logic [15:0] PH_LOAD  = 16'(T_PH - 1);
    localparam logic [15:0] BL_LOAD  = 16'(T_BL - 1);
    localparam logic [15:0] CMP_LOAD = 16'(CMP_CYCLES - 1);
    localparam logic [3:0]  NVOTE_W  = 4'(NVOTE);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  votes_q, votes_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  result_q, result_d;
    logic [7:0]  trial_q, trial_d;
    logic [7:0]  code_q, code_d;
    logic        valid_q, valid_d;

    logic        sample;
    logic        clear;
    logic        majority;
    logic [3:0]  ones;
    logic [3:0]  votes_inc;
    logic [7:0]  decided;
    logic        cnt_last;

    cmp_vote #(.NVOTE(NVOTE)) u_vote (
        .clk         (clk),
        .rst_n       (reset_n),
        .cmp_async_i (cmp_o),
        .sample_i    (sample),
        .clear_i     (clear),
        .ones_o      (ones),
        .majority_o  (majority)
    );

    assign cnt_last  = (cnt_q == 16'd0);
    assign votes_inc = votes_q + 4'd1;
    // result_q only holds resolved bits; the trial bit is kept unless the comparator says "too high".
    assign decided   = majority ? result_q : (result_q | bit_mask(bit_q));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        votes_d  = votes_q;
        bit_d    = bit_q;
        result_d = result_q;
        trial_d  = trial_q;
        code_d   = code_q;
        valid_d  = valid_q;
        sample   = 1'b0;
        clear    = 1'b0;
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            votes_d = 4'd0;
            clear   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d  = DIODE;
                        cnt_d    = PH_LOAD;
                        votes_d  = 4'd0;
                        bit_d    = 3'd7;
                        result_d = 8'h00;
                        trial_d  = IB_MID;
                        valid_d  = 1'b0;
                        clear    = 1'b1;
                    end
                end
                DIODE: begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_last) begin
                        state_d = BLANK1;
                        cnt_d   = BL_LOAD;
                    end
                end
                BLANK1: begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_last) begin
                        state_d = BIGDIODE;
                        cnt_d   = PH_LOAD;
                    end
                end
                BIGDIODE: begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_last) begin
                        state_d = BLANK2;
                        cnt_d   = BL_LOAD;
                    end
                end
                BLANK2: begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_last) begin
                        state_d = COMPARE;
                        cnt_d   = CMP_LOAD;
                    end
                end
                COMPARE: begin
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_last) begin
                        sample  = 1'b1;
                        votes_d = votes_inc;
                        if (votes_inc < NVOTE_W) begin
                            state_d = DIODE;
                            cnt_d   = PH_LOAD;
                        end else begin
                            state_d = DECIDE;
                            cnt_d   = 16'd0;
                        end
                    end
                end
                DECIDE: begin
                    clear    = 1'b1;
                    votes_d  = 4'd0;
                    result_d = decided;
                    if (bit_q == 3'd0) begin
                        state_d = DONE;
                        trial_d = decided;
                        code_d  = decided;
                        valid_d = 1'b1;
                    end else begin
                        state_d = DIODE;
                        cnt_d   = PH_LOAD;
                        bit_d   = bit_q - 3'd1;
                        trial_d = decided | bit_mask(bit_q - 3'd1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 16'd0;
            votes_q  <= 4'd0;
            bit_q    <= 3'd0;
            result_q <= 8'h00;
            trial_q  <= IB_MID;
            code_q   <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            votes_q  <= votes_d;
            bit_q    <= bit_d;
            result_q <= result_d;
            trial_q  <= trial_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
        end
    end

    // Front-end drive is decoded straight from state so reset and abort take effect without a register stage.
    always_comb begin
        res_n = 1'b1;
        diode = DIODE_BIG;
        c1    = C_OFF;
        c2    = C_OFF;
        case (state_q)
            DIODE: begin
                diode = DIODE_SMALL;
                c1    = C_CHARGE;
            end
            BLANK1: begin
                diode = DIODE_SMALL;
            end
            BIGDIODE: begin
                res_n = 1'b0;
                c2    = C_CHARGE;
            end
            BLANK2: begin
                res_n = 1'b0;
            end
            COMPARE: begin
                res_n = 1'b0;
                c1    = C_HOLD;
                c2    = C_HOLD;
            end
            default: begin
                res_n = 1'b1;
            end
        endcase
    end

    assign ib     = (state_q == IDLE) ? (valid_q ? code_q : IB_MID) : trial_q;
    assign busy   = (state_q != IDLE) && (state_q != DONE);
    assign done   = (state_q == DONE);
    assign valid  = valid_q;
    assign code_o = code_q;

endmodule

// File: doc/ib_sar_trim_ctrl.md
Name: ib_sar_trim_ctrl

Overview:
Sequencer that trims the 8-bit bias current code `ib` by successive approximation (SAR) against the comparator.
- Replays the diode / blank / big-diode / blank / compare measurement cycle once per vote, and runs NVOTE votes per bit.
- Takes a majority decision per bit and resolves the code MSB first.
- Reports the result through a start/busy/done handshake.
- Sits between the digital top and the analog front end, and drives its switch and capacitor controls directly.

Parameters:
T_PH, 1, cycles spent in each diode phase (DIODE, BIGDIODE); legal range ≥1.
T_BL, 1, cycles spent in each blanking phase (BLANK1, BLANK2); legal range ≥1.
NVOTE, 1, comparator samples per bit; odd only, range 1..15.

Ports:
clk  in  1  system clock, 10 MHz.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; honoured only in IDLE.
abort  in  1  cancels a conversion; takes priority over start.
cmp_o  in  1  raw comparator output, asynchronous to clk; 1 = measured level above reference.
ib  out  8  bias code driven to the IDAC.
res_n  out  1  reset switch for the sense node, active-low.
diode  out  8  diode-select mask.
c1  out  2  capacitor-1 control.
c2  out  2  capacitor-2 control.
busy  out  1  conversion in progress.
done  out  1  one-cycle pulse when a conversion completes.
valid  out  1  code_o holds a completed result.
code_o  out  8  final trimmed code.

Behaviour:
- Reset (async on reset_n low) applies these values:
  - state=IDLE, ib=8'h80, code_o=0, valid=0, busy=0, done=0.
  - diode=8'hFF, res_n=1, c1=0, c2=0.
  - Synchronizer, vote counter and bit index cleared.
- cmp_o passes through a 2-flop synchronizer before any use.
- IDLE:
  - ib=code_o if valid, else 8'h80.
  - start=1 and abort=0 → busy=1, valid=0, bit=7, result=0, ib=8'h80, go to DIODE.
- Measurement cycle, each state held for the stated count via a down-counter:
  - DIODE (T_PH): res_n=1, diode=8'h01, c1=2, c2=0.
  - BLANK1 (T_BL): c1=0.
  - BIGDIODE (T_PH): res_n=0, diode=8'hFF, c2=2.
  - BLANK2 (T_BL): c2=0.
  - COMPARE (3 cycles): c1=1, c2=1. The synchronized cmp_o is sampled on the last cycle; if sampled 1, the ones-count increments.
  - After COMPARE, if fewer than NVOTE samples have been taken → DIODE; otherwise → DECIDE.
- DECIDE (1 cycle):
  - Majority rule: if ones > NVOTE/2, clear result[bit]; otherwise keep it set.
  - Clear the ones-count.
  - If bit==0 → DONE. Otherwise bit−1, ib = result | (1<<(bit−1)), go to DIODE.
  - Arithmetic is 8-bit unsigned with no wrap; bit-mask operations only.
- DONE (1 cycle): code_o=result, ib=result, valid=1, done=1, busy=0, diode=8'hFF, res_n=1, c1=c2=0 → IDLE.
- Latency: done is high in the cycle beginning at start-edge + 8·(NVOTE·(2·T_PH+2·T_BL+3)+1) + 1. With defaults this is 65.
- start while busy is ignored and has no side effects.
- abort in any non-IDLE state:
  - Go to IDLE next edge; busy=0, valid=0, no done pulse.
  - Front-end outputs return to idle values; code_o is unchanged.
- start and abort in the same cycle: abort wins and start is dropped.
- reset_n low mid-conversion: immediate return to reset values; no done pulse.

Decomposition:
- Package ib_sar_trim_pkg holds:
  - state_t enum: IDLE, DIODE, BLANK1, BIGDIODE, BLANK2, COMPARE, DECIDE, DONE.
  - Constants: DIODE_SMALL=8'h01, DIODE_BIG=8'hFF, C_CHARGE=2'd2, C_HOLD=2'd1, C_OFF=2'd0, IB_MID=8'h80, CMP_CYCLES=3.
- Sub-module cmp_vote contains the 2-flop synchronizer, sample strobe input, ones counter, clear input and majority output.

Test Plan:
- Defaults, comparator model cmp_o=(ib>8'h5A), pulse start → code_o=8'h5A, valid=1, done pulses at cycle 65, busy high for cycles 1..64.
- Model target 8'hFF → code_o=8'hFF. cmp_o tied 1 → code_o=8'h00. cmp_o tied 0 → code_o=8'hFF.
- NVOTE=3, target 8'h3C, one of the three samples forced to the wrong value on bits 6 and 2 → code_o=8'h3C; latency = 8·(3·7+1)+1 = 177.
- Abort asserted at cycle 20 of a run (prior valid result 8'h11) → busy=0 next cycle, valid=0, code_o stays 8'h11, no done pulse. A new start then completes normally.
- start pulsed at cycles 10 and 30 during a run → ignored and result unchanged. start and abort in the same cycle from IDLE → stays IDLE.
- reset_n low at cycle 40 → all outputs at reset values asynchronously; after release, a start yields the correct code.
